camlink_frame_counter: RTL and testbench

- Timing monitor and counter for a deserialized Camera Link base-configuration port: 28-bit parallel word per pixel clock.
- Extracts FVAL/LVAL/DVAL and the 24-bit pixel taps, registers them, and counts pixels per line, lines per frame and frames.
- Produces frame/line start/end strobes, last-line/last-frame size measurements, a protocol-error flag and a free-running cycle counter.
- Sits directly behind the Camera Link deserializer; feeds video capture and status registers.

---
 rtl/camlink_frame_counter.sv | 181 ++++++++++++++++++
 tb/tb_camlink_frame_counter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camlink_frame_counter.sv
// Camera Link base-port timing monitor: registers the pixel taps and control bits,
// derives frame/line strobes, pixel/line/frame counters, size captures and a stray-LVAL flag.
module camlink_frame_counter #(
    parameter int PIX_W    = 16,
    parameter int LINE_W   = 16,
    parameter int FRAME_W  = 32,
    parameter int CYC_W    = 32,
    parameter int FVAL_BIT = 26,
    parameter int LVAL_BIT = 24,
    parameter int DVAL_BIT = 25,
    parameter int USE_DVAL = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [27:0]        cl_d,
    output logic [23:0]        pix_data,
    output logic               pix_valid,
    output logic               frame_start,
    output logic               frame_end,
    output logic               line_start,
    output logic               line_end,
    output logic [PIX_W-1:0]   pix_cnt,
    output logic [LINE_W-1:0]  line_cnt,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [PIX_W-1:0]   last_line_pix,
    output logic [LINE_W-1:0]  last_frame_lines,
    output logic               err_lval,
    input  logic               err_clr,
    output logic [CYC_W-1:0]   cyc_cnt
);
    localparam logic [PIX_W-1:0]   PIX_ONE   = {{(PIX_W-1){1'b0}}, 1'b1};
    localparam logic [PIX_W-1:0]   PIX_MAX   = {PIX_W{1'b1}};
    localparam logic [LINE_W-1:0]  LINE_ONE  = {{(LINE_W-1){1'b0}}, 1'b1};
    localparam logic [LINE_W-1:0]  LINE_MAX  = {LINE_W{1'b1}};
    localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0]   CYC_ONE   = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic               DVAL_EN   = (USE_DVAL != 32'sd0);

    logic [27:0]       d_r;
    logic              fv_p_r;
    logic              lv_p_r;
    logic              fv_s;
    logic              lv_s;
    logic              dv_s;
    logic              in_line_s;
    logic              pen_s;
    logic              fs_s;
    logic              fe_s;
    logic              ls_s;
    logic              le_s;
    logic              err_set_s;
    logic [PIX_W-1:0]  pix_inc_s;
    logic [LINE_W-1:0] line_inc_s;
    logic              spare_unused_s;

    assign spare_unused_s = d_r[27];

    // Stage-1 capture of the deserialized word and the previous FVAL/LVAL levels
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_r    <= 28'h0;
            fv_p_r <= 1'b0;
            lv_p_r <= 1'b0;
        end else begin
            d_r    <= cl_d;
            fv_p_r <= fv_s;
            lv_p_r <= lv_s;
        end
    end

    // Decode control bits and edge events; a line is only "active" while FVAL is also high
    always_comb begin
        fv_s      = d_r[FVAL_BIT];
        lv_s      = d_r[LVAL_BIT];
        dv_s      = d_r[DVAL_BIT];
        in_line_s = fv_s & lv_s;
        pen_s     = in_line_s & (DVAL_EN ? dv_s : 1'b1);
        fs_s      = fv_s & ~fv_p_r;
        fe_s      = ~fv_s & fv_p_r;
        ls_s      = in_line_s & ~(lv_p_r & fv_p_r);
        le_s      = (lv_p_r & fv_p_r) & ~in_line_s;
        err_set_s = lv_s & ~fv_s;
        if (pix_cnt != PIX_MAX) begin
            pix_inc_s = pix_cnt + PIX_ONE;
        end else begin
            pix_inc_s = pix_cnt;
        end
        if (line_cnt != LINE_MAX) begin
            line_inc_s = line_cnt + LINE_ONE;
        end else begin
            line_inc_s = line_cnt;
        end
    end

    // Stage-2 video word, qualifier and timing strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_data    <= 24'h0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            pix_data    <= d_r[23:0];
            pix_valid   <= pen_s;
            frame_start <= fs_s;
            frame_end   <= fe_s;
            line_start  <= ls_s;
            line_end    <= le_s;
        end
    end

    // Pixel counter; it holds after line end so software can still read it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_cnt       <= {PIX_W{1'b0}};
            last_line_pix <= {PIX_W{1'b0}};
        end else begin
            if (ls_s) begin
                pix_cnt <= pen_s ? PIX_ONE : {PIX_W{1'b0}};
            end else if (pen_s) begin
                pix_cnt <= pix_inc_s;
            end else begin
                pix_cnt <= pix_cnt;
            end
            if (le_s) begin
                last_line_pix <= pix_cnt;
            end else begin
                last_line_pix <= last_line_pix;
            end
        end
    end

    // Line and frame counters; a line closed by the FVAL fall is counted into that frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_cnt         <= {LINE_W{1'b0}};
            last_frame_lines <= {LINE_W{1'b0}};
            frame_cnt        <= {FRAME_W{1'b0}};
        end else begin
            if (fs_s) begin
                line_cnt <= {LINE_W{1'b0}};
            end else if (le_s) begin
                line_cnt <= line_inc_s;
            end else begin
                line_cnt <= line_cnt;
            end
            if (fe_s) begin
                last_frame_lines <= le_s ? line_inc_s : line_cnt;
                frame_cnt        <= frame_cnt + FRAME_ONE;
            end else begin
                last_frame_lines <= last_frame_lines;
                frame_cnt        <= frame_cnt;
            end
        end
    end

    // Sticky stray-LVAL flag; a new violation outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_lval <= 1'b0;
        end else if (err_set_s) begin
            err_lval <= 1'b1;
        end else if (err_clr) begin
            err_lval <= 1'b0;
        end else begin
            err_lval <= err_lval;
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt <= {CYC_W{1'b0}};
        end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
        end
    end

endmodule

// File: tb/tb_camlink_frame_counter.sv
// Bench for camlink_frame_counter: two instances (DVAL ignored / DVAL qualified) driven by
// directed and random Camera Link streams, checked against an event-level reference model.
module tb_camlink_frame_counter;
    logic        clk     = 1'b0;
    logic        rstn    = 1'b1;
    logic [27:0] cl_d    = 28'h0;
    logic        err_clr = 1'b0;

    logic [23:0] pd_o   [2];
    logic        pv_o   [2];
    logic        fs_o   [2];
    logic        fe_o   [2];
    logic        ls_o   [2];
    logic        le_o   [2];
    logic [15:0] pix_o  [2];
    logic [15:0] line_o [2];
    logic [31:0] frm_o  [2];
    logic [15:0] llp_o  [2];
    logic [15:0] lfl_o  [2];
    logic        err_o  [2];
    logic [31:0] cyc_o  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        camlink_frame_counter #(.USE_DVAL(g)) dut (
            .clk(clk), .rstn(rstn), .cl_d(cl_d),
            .pix_data(pd_o[g]), .pix_valid(pv_o[g]),
            .frame_start(fs_o[g]), .frame_end(fe_o[g]),
            .line_start(ls_o[g]), .line_end(le_o[g]),
            .pix_cnt(pix_o[g]), .line_cnt(line_o[g]), .frame_cnt(frm_o[g]),
            .last_line_pix(llp_o[g]), .last_frame_lines(lfl_o[g]),
            .err_lval(err_o[g]), .err_clr(err_clr), .cyc_cnt(cyc_o[g])
        );
    end

    // Reference model state (index 0: DVAL ignored, index 1: DVAL qualifies pixels)
    int unsigned m_pix [2];
    int unsigned m_lines [2];
    int unsigned m_frames [2];
    int unsigned m_llp [2];
    int unsigned m_lfl [2];
    bit          m_pv [2];
    bit          m_err [2];
    bit          m_fs, m_fe, m_ls, m_le, m_fvp, m_lvp;
    logic [23:0] m_pd;
    int unsigned m_cyc;
    logic [27:0] prev_w;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [157:0] dut_pack(input int i);
        return {pd_o[i], pv_o[i], fs_o[i], fe_o[i], ls_o[i], le_o[i], pix_o[i], line_o[i],
                frm_o[i], llp_o[i], lfl_o[i], err_o[i], cyc_o[i]};
    endfunction

    function automatic logic [157:0] model_pack(input int i);
        return {m_pd, m_pv[i], m_fs, m_fe, m_ls, m_le, m_pix[i][15:0], m_lines[i][15:0],
                m_frames[i], m_llp[i][15:0], m_lfl[i][15:0], m_err[i], m_cyc};
    endfunction

    function automatic logic [27:0] mk(input logic fv, input logic lv, input logic dv);
        logic [27:0] w;
        w     = 28'($urandom());
        w[26] = fv;
        w[25] = dv;
        w[24] = lv;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pix[i] = 0; m_lines[i] = 0; m_frames[i] = 0;
            m_llp[i] = 0; m_lfl[i] = 0; m_pv[i] = 1'b0; m_err[i] = 1'b0;
        end
        m_fs = 1'b0; m_fe = 1'b0; m_ls = 1'b0; m_le = 1'b0;
        m_fvp = 1'b0; m_lvp = 1'b0; m_pd = 24'h0; m_cyc = 0; prev_w = 28'h0;
    endtask

    // Model: account one sampled word against the frame/line rules
    task automatic model_step(input logic [27:0] w, input logic clr);
        bit fv, lv, dv, act, pact, pen;
        fv   = w[26];
        lv   = w[24];
        dv   = w[25];
        act  = fv && lv;
        pact = m_fvp && m_lvp;
        m_fs = fv && !m_fvp;
        m_fe = !fv && m_fvp;
        m_ls = act && !pact;
        m_le = pact && !act;
        m_pd = w[23:0];
        for (int i = 0; i < 2; i++) begin
            pen     = act && (i == 0 || dv);
            m_pv[i] = pen;
            if (m_le) begin
                m_llp[i] = m_pix[i];
                if (m_lines[i] < 65535) m_lines[i]++;
            end
            if (m_fe) begin
                m_lfl[i] = m_lines[i];
                m_frames[i]++;
            end
            if (m_fs) m_lines[i] = 0;
            if (m_ls) m_pix[i] = pen ? 1 : 0;
            else if (pen && m_pix[i] < 65535) m_pix[i]++;
            if (lv && !fv) m_err[i] = 1'b1;
            else if (clr) m_err[i] = 1'b0;
        end
        m_fvp = fv;
        m_lvp = lv;
        m_cyc++;
    endtask

    // One clock: drive, let the edge pass, advance the model by the word now in stage 2
    task automatic step(input logic [27:0] w, input logic clr);
        cl_d    = w;
        err_clr = clr;
        @(posedge clk);
        #1;
        model_step(prev_w, clr);
        prev_w = w;
    endtask

    task automatic do_reset();
        cl_d    = 28'h0;
        err_clr = 1'b0;
        rstn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        cl_d = 28'h5000000;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_pack(i) !== 158'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d got=%h exp=0", i, dut_pack(i));
            end
        end
        model_reset();
        rstn = 1'b1;
    endtask

    task automatic test_first_line();
        for (int k = 0; k < 852; k++) begin
            step((k < 850) ? 28'h5000000 : 28'h4000000, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_pack(i) !== model_pack(i)) begin
                    n_fail++;
                    $display("FAIL first_line k%0d dut%0d got=%h exp=%h", k, i, dut_pack(i), model_pack(i));
                end
            end
            if (k == 1) begin
                n_cmp++;
                if ({fs_o[0], ls_o[0], pv_o[0], pix_o[0]} !== {3'b111, 16'd1}) begin
                    n_fail++;
                    $display("FAIL first_strobes got fs=%b ls=%b pv=%b pix=%0d exp 1 1 1 1",
                             fs_o[0], ls_o[0], pv_o[0], pix_o[0]);
                end
            end
        end
        n_cmp++;
        if ({le_o[0], pv_o[0], llp_o[0], line_o[0], pix_o[0]} !== {2'b10, 16'd850, 16'd1, 16'd850}) begin
            n_fail++;
            $display("FAIL line_end le=%b pv=%b llp=%0d lines=%0d pix=%0d exp 1 0 850 1 850",
                     le_o[0], pv_o[0], llp_o[0], line_o[0], pix_o[0]);
        end
    endtask

    task automatic test_frame_end();
        for (int k = 0; k < 3; k++) begin
            step(28'h1000000, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_pack(i) !== model_pack(i)) begin
                    n_fail++;
                    $display("FAIL frame_end k%0d dut%0d got=%h exp=%h", k, i, dut_pack(i), model_pack(i));
                end
            end
            if (k == 1) begin
                n_cmp++;
                if ({fe_o[0], ls_o[0], frm_o[0], lfl_o[0]} !== {2'b10, 32'd1, 16'd1}) begin
                    n_fail++;
                    $display("FAIL frame_end_vals fe=%b ls=%b frames=%0d lfl=%0d exp 1 0 1 1",
                             fe_o[0], ls_o[0], frm_o[0], lfl_o[0]);
                end
            end
        end
        n_cmp++;
        if (err_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set got=%b exp=1", err_o[0]);
        end
    endtask

    task automatic test_err_clr();
        logic [27:0] ws [7];
        logic        cs [7];
        logic        es [7];
        ws = '{28'h0, 28'h0, 28'h1000000, 28'h1000000, 28'h1000000, 28'h0, 28'h0};
        cs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        es = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            step(ws[k], cs[k]);
            n_cmp++;
            if (err_o[0] !== es[k] || err_o[1] !== es[k]) begin
                n_fail++;
                $display("FAIL err_clr k%0d got=%b%b exp=%b", k, err_o[0], err_o[1], es[k]);
            end
            n_cmp++;
            if (dut_pack(0) !== model_pack(0)) begin
                n_fail++;
                $display("FAIL err_clr_state k%0d got=%h exp=%h", k, dut_pack(0), model_pack(0));
            end
        end
    endtask

    task automatic test_frames();
        logic [27:0] sq [$];
        int          tap_idx;
        do_reset();
        tap_idx = -1;
        for (int f = 0; f < 3; f++) begin
            repeat (2) sq.push_back(28'h4000000);
            for (int l = 0; l < 4; l++) begin
                for (int p = 0; p < 10; p++) begin
                    if (f == 1 && l == 2 && p == 9) begin
                        tap_idx = sq.size();
                        sq.push_back(28'h7A5B6C7);
                    end else begin
                        sq.push_back(mk(1'b1, 1'b1, 1'b1));
                    end
                end
                repeat (3) sq.push_back(28'h4000000);
            end
            repeat (5) sq.push_back(28'h0);
        end
        foreach (sq[k]) begin
            step(sq[k], 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_pack(i) !== model_pack(i)) begin
                    n_fail++;
                    $display("FAIL frames k%0d dut%0d got=%h exp=%h", k, i, dut_pack(i), model_pack(i));
                end
            end
            if (k == tap_idx + 1) begin
                n_cmp++;
                if (pd_o[0] !== 24'hA5B6C7) begin
                    n_fail++;
                    $display("FAIL tap_latency got=%h exp=a5b6c7", pd_o[0]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({llp_o[i], lfl_o[i], frm_o[i]} !== {16'd10, 16'd4, 32'd3}) begin
                n_fail++;
                $display("FAIL frames_totals dut%0d llp=%0d lfl=%0d frames=%0d exp 10 4 3",
                         i, llp_o[i], lfl_o[i], frm_o[i]);
            end
        end
    endtask

    task automatic test_dval();
        logic [27:0] sq [$];
        repeat (2) sq.push_back(28'h4000000);
        for (int p = 0; p < 10; p++) sq.push_back(mk(1'b1, 1'b1, 1'((p % 2) == 0)));
        repeat (2) sq.push_back(28'h4000000);
        repeat (3) sq.push_back(28'h0);
        foreach (sq[k]) begin
            step(sq[k], 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_pack(i) !== model_pack(i)) begin
                    n_fail++;
                    $display("FAIL dval k%0d dut%0d got=%h exp=%h", k, i, dut_pack(i), model_pack(i));
                end
            end
        end
        n_cmp++;
        if (llp_o[1] !== 16'd5 || llp_o[0] !== 16'd10) begin
            n_fail++;
            $display("FAIL dval_count got dval=%0d nodval=%0d exp 5 10", llp_o[1], llp_o[0]);
        end
    endtask

    task automatic test_random();
        logic [27:0] sq [$];
        logic        cq [$];
        int          nl, np;
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(1, 4);
            np = $urandom_range(1, 12);
            repeat ($urandom_range(0, 2)) begin
                sq.push_back(mk(1'b1, 1'b0, 1'($urandom))); cq.push_back(1'($urandom));
            end
            for (int l = 0; l < nl; l++) begin
                repeat (np) begin
                    sq.push_back(mk(1'b1, 1'b1, 1'($urandom))); cq.push_back(1'b0);
                end
                if (l < nl - 1 || $urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 3)) begin
                        sq.push_back(mk(1'b1, 1'b0, 1'($urandom))); cq.push_back(1'b0);
                    end
                end
            end
            repeat ($urandom_range(1, 5)) begin
                sq.push_back(mk(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom)));
                cq.push_back(1'($urandom_range(0, 2) == 0));
            end
        end
        foreach (sq[k]) begin
            step(sq[k], cq[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_pack(i) !== model_pack(i)) begin
                    n_fail++;
                    $display("FAIL random k%0d dut%0d got=%h exp=%h", k, i, dut_pack(i), model_pack(i));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (2) step(28'h4000000, 1'b0);
        repeat (5) step(28'h5000000, 1'b0);
        #2 rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_pack(i) !== 158'd0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d got=%h exp=0", i, dut_pack(i));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(28'h5000000, 1'b0);
            n_cmp++;
            if (dut_pack(0) !== model_pack(0)) begin
                n_fail++;
                $display("FAIL post_reset k%0d got=%h exp=%h", k, dut_pack(0), model_pack(0));
            end
            if (k == 1) begin
                n_cmp++;
                if (cyc_o[0] !== 32'd2 || fs_o[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart got cyc=%0d fs=%b exp 2 1", cyc_o[0], fs_o[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame_end();
        test_err_clr();
        test_frames();
        test_dval();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
